// File: rtl/rsa_operand_sequencer.sv
// RSA operand sequencer: collects base, exponent and modulus words from the
// deserializer, launches the modexp core, waits for its result (with a
// timeout) and hands the result word to the serializer.
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOAD_B | waiting for the base word
// LOAD_E | waiting for the exponent word
// LOAD_M | waiting for the modulus word
// START  | pulse core_start (or short-circuit a zero modulus to result 0)
// WAIT   | counting cycles until core_done or timeout
// SEND   | waiting for the serializer to be free, then strobe tx_valid
module rsa_operand_sequencer #(
  parameter int N       = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_bytes,
  output logic         core_start,
  output logic [N-1:0] core_base,
  output logic [N-1:0] core_exp,
  output logic [N-1:0] core_mod,
  input  logic         core_done,
  input  logic [N-1:0] core_result,
  output logic [N-1:0] tx_bytes,
  output logic         tx_valid,
  input  logic         tx_busy,
  output logic         overrun,
  output logic         timed_out
);

  // The wait counter holds the number of cycles elapsed since core_start.
  // It is cleared when the modulus is accepted and counts the START cycle,
  // so in WAIT it reads 1, 2, ...; the last WAIT cycle is TIMEOUT-1 and the
  // counter reaches TIMEOUT on leaving WAIT. TIMEOUT is expected to be >= 2.
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD_B,
    LOAD_E,
    LOAD_M,
    START,
    WAIT,
    SEND
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  base_q, base_d;
  logic [N-1:0]  exp_q, exp_d;
  logic [N-1:0]  mod_q, mod_d;
  logic [N-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d;
  logic          timed_out_q, timed_out_d;
  logic          start_pulse;
  logic          tx_pulse;

  // Next-state, operand/result capture and one-cycle strobes.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    exp_d       = exp_q;
    mod_d       = mod_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    timed_out_d = timed_out_q;
    start_pulse = 1'b0;
    tx_pulse    = 1'b0;

    case (state_q)
      LOAD_B: begin
        if (rx_valid) begin
          base_d  = rx_bytes;
          state_d = LOAD_E;
        end
      end
      LOAD_E: begin
        if (rx_valid) begin
          exp_d   = rx_bytes;
          state_d = LOAD_M;
        end
      end
      LOAD_M: begin
        if (rx_valid) begin
          mod_d   = rx_bytes;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // x mod 0 is undefined; answer 0 without bothering the core.
        if (mod_q == '0) begin
          result_d = '0;
          state_d  = SEND;
        end else begin
          start_pulse = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // core_done takes priority over a timeout in the same cycle.
        if (core_done) begin
          result_d = core_result;
          state_d  = SEND;
        end else if (cnt_q == CNT_LAST) begin
          result_d    = '1;
          timed_out_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_pulse = 1'b1;
          state_d  = LOAD_B;
        end
      end
      default: state_d = LOAD_B;
    endcase

    // A word arriving while an operation is in flight is lost; flag it.
    if (rx_valid && (state_q == START || state_q == WAIT || state_q == SEND))
      overrun_d = 1'b1;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_B;
      base_q      <= '0;
      exp_q       <= '0;
      mod_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      mod_q       <= mod_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      timed_out_q <= timed_out_d;
    end
  end

  // result_q only changes on entry to SEND, so it doubles as the held tx word.
  assign core_start = start_pulse;
  assign tx_valid   = tx_pulse;
  assign tx_bytes   = result_q;
  assign core_base  = base_q;
  assign core_exp   = exp_q;
  assign core_mod   = mod_q;
  assign overrun    = overrun_q;
  assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// Testbench for rsa_operand_sequencer: transaction-level reference model
// with a behavioural modexp core responder and randomized traffic.
module tb_rsa_operand_sequencer;

  localparam int N  = 16;
  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [N-1:0] rx_bytes = '0;
  logic         core_done = 1'b0;
  logic [N-1:0] core_result = '0;
  logic         tx_busy = 1'b0;
  logic         core_start;
  logic [N-1:0] core_base, core_exp, core_mod, tx_bytes;
  logic         tx_valid, overrun, timed_out;

  int checks = 0;
  int failures = 0;
  bit exp_ovr = 1'b0;
  bit exp_to = 1'b0;

  always #5 clk = ~clk;

  rsa_operand_sequencer #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_bytes(rx_bytes),
    .core_start(core_start), .core_base(core_base), .core_exp(core_exp),
    .core_mod(core_mod), .core_done(core_done), .core_result(core_result),
    .tx_bytes(tx_bytes), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .overrun(overrun), .timed_out(timed_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] modexp(input logic [N-1:0] b, e, m);
    longint r, x;
    r = 1 % longint'(m);
    x = longint'(b) % longint'(m);
    for (int i = 0; i < int'(e); i++) r = (r * x) % longint'(m);
    return N'(r);
  endfunction

  // One word on rx; in the idle gap afterwards, stray core_done strobes are
  // thrown at the DUT (they must be ignored outside WAIT).
  task automatic send_word(input logic [N-1:0] w, input int gap);
    rx_valid  = 1'b1;
    rx_bytes  = w;
    core_done = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      core_done   = 1'($urandom_range(0, 1));
      core_result = N'($urandom);
      @(negedge clk);
    end
    core_done = 1'b0;
  endtask

  // dly: cycle after core_start at which the core answers (0 = never).
  // busy_until: tx_busy is high for cycles 0..busy_until-1 after core_start.
  // poke_k: cycle after core_start at which a stray rx word arrives (<0 none).
  task automatic txn(input logic [N-1:0] b, e, m, input int dly, input int busy_until,
                     input int poke_k, input logic [N-1:0] poke_val);
    int send_k, exp_k, tx_k, starts, txs, both, unstable, pk;
    logic [N-1:0] res, exp_val, got_val;
    bit to_now;
    tx_k = -1; starts = 0; txs = 0; both = 0; unstable = 0; to_now = 1'b0;
    got_val = '0;
    res = (m != 0) ? modexp(b, e, m) : '0;
    if (m == 0) begin
      send_k = 1; exp_val = '0;
    end else if (dly >= 1 && dly <= TO - 1) begin
      send_k = dly + 1; exp_val = res;
    end else begin
      send_k = TO; exp_val = '1; to_now = 1'b1;
    end
    exp_k = (busy_until > send_k) ? busy_until : send_k;
    pk = (poke_k > exp_k) ? -1 : poke_k;

    send_word(b, $urandom_range(0, 2));
    send_word(e, $urandom_range(0, 2));
    send_word(m, 0);
    for (int k = 0; k <= exp_k + 5; k++) begin
      if (k > 0) @(negedge clk);
      core_done   = (dly > 0 && k == dly);
      core_result = (core_done && m != 0) ? res : N'($urandom);
      tx_busy     = (k < busy_until);
      rx_valid    = (k == pk);
      rx_bytes    = poke_val;
      #1;
      if (k == 0) begin
        check_eq("base_at_start", core_base, b);
        check_eq("exp_at_start", core_exp, e);
        check_eq("mod_at_start", core_mod, m);
      end
      if (core_start) starts++;
      if (core_start && tx_valid) both++;
      if ({core_base, core_exp, core_mod} !== {b, e, m}) unstable++;
      if (tx_valid) begin
        txs++;
        tx_k = k;
        got_val = tx_bytes;
      end
      if (tx_k >= 0) break;
    end
    @(negedge clk);
    core_done = 1'b0; rx_valid = 1'b0; tx_busy = 1'b0;
    #1;
    if (txs == 0 && tx_valid) txs++;
    exp_ovr = exp_ovr | (pk >= 0);
    exp_to  = exp_to | to_now;
    check_eq("core_start_count", starts, (m != 0) ? 1 : 0);
    check_eq("tx_cycle", tx_k, exp_k);
    check_eq("tx_bytes", got_val, exp_val);
    check_eq("tx_valid_count", txs, 1);
    check_eq("start_tx_overlap", both, 0);
    check_eq("operands_stable", unstable, 0);
    check_eq("tx_valid_single", tx_valid, 1'b0);
    check_eq("tx_bytes_hold", tx_bytes, exp_val);
    check_eq("overrun", overrun, exp_ovr);
    check_eq("timed_out", timed_out, exp_to);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs",
             {core_base, core_exp, core_mod, tx_bytes, core_start, tx_valid, overrun, timed_out}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic, zero modulus, done-vs-timeout tie, done just after timeout
    txn(16'd4, 16'd13, 16'd497, 20, 0, -1, '0);
    txn(16'd7, 16'd3, 16'd0, 3, 0, -1, '0);
    txn(16'd3, 16'd5, 16'd101, TO - 1, 0, -1, '0);
    txn(16'd9, 16'd2, 16'd77, TO, 0, -1, '0);
    // core never answers
    txn(16'd5, 16'd6, 16'd1234, 0, 0, -1, '0);
    // backpressure for 100 cycles after core_done, stray word 9 in WAIT
    txn(16'd11, 16'd7, 16'd300, 10, 111, 5, 16'd9);
    txn(16'd21, 16'd4, 16'd55, 8, 0, -1, '0);

    // reset while loading the modulus
    send_word(16'd3, 1);
    send_word(16'd5, 0);
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_load",
             {core_base, core_exp, core_mod, tx_bytes, core_start, tx_valid, overrun, timed_out}, '0);
    exp_ovr = 1'b0;
    exp_to  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(16'd2, 16'd10, 16'd1000, 15, 0, -1, '0);

    for (int t = 0; t < 25; t++) begin
      logic [N-1:0] rb, re, rm;
      rb = N'($urandom);
      re = N'($urandom_range(0, 300));
      rm = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(1, 65535));
      txn(rb, re, rm, $urandom_range(0, 60),
          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 70) : 0,
          ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : -1, N'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_operand_sequencer.md
RSA_OPERAND_SEQUENCER -- requirements
Module: rsa_operand_sequencer

Interface
REQ-001 SHALL have parameter N, default 16: operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 65535: maximum number of cycles to wait for core_done.
REQ-003 SHALL have port clk, input, 1: the single system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle strobe indicating that rx_bytes holds a complete word from the deserializer.
REQ-006 SHALL have port rx_bytes, input, N: the received operand word.
REQ-007 SHALL have port core_start, output, 1: one-cycle start pulse to the modexp core.
REQ-008 SHALL have ports core_base, core_exp and core_mod, output, N each: registered operands, held stable from core_start until core_done.
REQ-009 SHALL have port core_done, input, 1: one-cycle strobe indicating that core_result is valid.
REQ-010 SHALL have port core_result, input, N: the modexp result.
REQ-011 SHALL have port tx_bytes, output, N: the result word sent to the serializer.
REQ-012 SHALL have port tx_valid, output, 1: one-cycle strobe indicating that tx_bytes is valid.
REQ-013 SHALL have port tx_busy, input, 1: serializer busy; while high, the serializer is not accepting a word.
REQ-014 SHALL have port overrun, output, 1: sticky flag; set when an rx_valid strobe arrives outside the load states.
REQ-015 SHALL have port timed_out, output, 1: sticky flag; set when a core timeout occurs.

Function
REQ-016 SHALL implement an FSM with the states LOAD_B, LOAD_E, LOAD_M, START, WAIT, SEND.
REQ-017 In LOAD_B, an rx_valid strobe SHALL latch rx_bytes into core_base and move the FSM to LOAD_E.
REQ-018 In LOAD_E, an rx_valid strobe SHALL latch rx_bytes into core_exp and move the FSM to LOAD_M.
REQ-019 In LOAD_M, an rx_valid strobe SHALL latch rx_bytes into core_mod and move the FSM to START.
REQ-020 In START, the block SHALL assert core_start for exactly one cycle, clear the wait counter and enter WAIT; core_start SHALL therefore be high the cycle after the LOAD_M strobe.
REQ-021 Exception to REQ-020: if core_mod == 0, the block SHALL NOT pulse core_start; it SHALL load result 0 and go directly to SEND.
REQ-022 In WAIT, core_done SHALL latch core_result into the result register and move the FSM to SEND.
REQ-023 In WAIT, the counter SHALL increment by one each cycle; when it reaches TIMEOUT with no core_done, the block SHALL load result {N{1'b1}}, set timed_out and go to SEND.
REQ-024 If core_done and the timeout occur in the same cycle, core_done SHALL win.
REQ-025 The wait counter SHALL be sized to hold TIMEOUT, SHALL saturate at TIMEOUT and SHALL never wrap.
REQ-026 In SEND, on the first cycle with tx_busy low, the block SHALL assert tx_valid for one cycle with tx_bytes = result, then return to LOAD_B.
REQ-027 tx_bytes SHALL hold its value until the next SEND.
REQ-028 An rx_valid strobe in START, WAIT or SEND SHALL be dropped and SHALL set overrun; it SHALL NOT alter any operand register or the FSM state.
REQ-029 A core_done strobe outside WAIT SHALL be ignored.
REQ-030 tx_valid and core_start SHALL never both be high in the same cycle; each SHALL be high for at most one cycle per transaction.
REQ-031 The FSM SHALL use back-to-back operation: after returning to LOAD_B, the next word SHALL be accepted on the immediately following rx_valid strobe.

Reset
REQ-032 While rst_n is low, the FSM SHALL be held in LOAD_B and the following SHALL be 0: core_base, core_exp, core_mod, result, tx_bytes, the wait counter, core_start, tx_valid, overrun, timed_out.
REQ-033 Reset assertion SHALL take effect immediately, without waiting for clk, including in the middle of a load, wait or send; any partially loaded operands SHALL be discarded.
REQ-034 After rst_n deasserts, the first rx_valid strobe SHALL be treated as the base word.

Verification
REQ-035 Basic transaction: send words 4, 13, 497; core model returns 445 after 20 cycles -> exactly one core_start pulse one cycle after the word 497; core_base/core_exp/core_mod = 4/13/497 and stable until core_done; a single tx_valid with tx_bytes = 445.
REQ-036 Zero modulus: send 7, 3, 0 -> no core_start; tx_valid with tx_bytes = 0.
REQ-037 Core timeout: TIMEOUT = 50 and core_done is never asserted -> tx_valid with tx_bytes = 0xFFFF (N = 16) exactly 50 cycles after core_start; timed_out = 1.
REQ-038 Backpressure and overrun: hold tx_busy high for 100 cycles after core_done and pulse rx_valid with 9 during WAIT -> overrun = 1; tx_valid is asserted the first cycle after tx_busy falls; the following transaction loads its base correctly, not 9.
REQ-039 Reset mid-operation: pulse rst_n low in LOAD_M after two words -> all outputs are 0 immediately; a new sequence 2, 10, 1000 returns 24.
REQ-040 Simultaneous events: core_done in the same cycle the counter reaches TIMEOUT -> the core result is sent and timed_out remains 0.
